mem_interface: RTL and testbench

- Word-addressed memory subsystem that sits upstream of the MDR and produces its Mdatain input.
- Owns the main RAM array.
- Accepts read/write requests from the control unit, using the address from MAR and the write data from MDRout.
- Inserts a programmable number of wait states and signals completion with a one-cycle mem_done pulse.

---
 rtl/mem_interface_pkg.sv | 16 +
 rtl/mem_interface_if.sv | 28 ++
 rtl/mem_interface_ram_array.sv | 24 ++
 rtl/mem_interface.sv | 120 ++++++++++++
 tb/tb_mem_interface.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mem_interface_pkg.sv
// Shared definitions for the mem_interface memory subsystem: bus width,
// default RAM index width and the FSM state encoding.
package mem_interface_pkg;

   localparam int DATA_W         = 32;
   localparam int MAR_W          = 32;
   localparam int ADDR_W_DEFAULT = 9;
   localparam int CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_interface_if.sv
// Control-unit <-> memory handshake bundle. The addr_err flag exists only
// when MEM_BOUNDS_CHECK_EN is defined.
interface mem_interface_if;
   import mem_interface_pkg::*;

   logic              read;
   logic              write;
   logic [MAR_W-1:0]  MARout;
   logic [DATA_W-1:0] MDRout;
   logic [DATA_W-1:0] Mdatain;
   logic              mem_done;
   logic              busy;

`ifdef MEM_BOUNDS_CHECK_EN
   logic              addr_err;

   modport master (output read, write, MARout, MDRout,
                   input  Mdatain, mem_done, busy, addr_err);
   modport slave  (input  read, write, MARout, MDRout,
                   output Mdatain, mem_done, busy, addr_err);
`else
   modport master (output read, write, MARout, MDRout,
                   input  Mdatain, mem_done, busy);
   modport slave  (input  read, write, MARout, MDRout,
                   output Mdatain, mem_done, busy);
`endif

endinterface

// File: rtl/mem_interface_ram_array.sv
// Single-port RAM for mem_interface: synchronous write, combinational read,
// so the caller can register read data on the same edge that commits a write.
module ram_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   assign dout = mem[addr];

endmodule

// File: rtl/mem_interface.sv
// Word-addressed memory front end with programmable wait states and a
// one-cycle mem_done pulse. Optional range check: MEM_BOUNDS_CHECK_EN.
module mem_interface
   import mem_interface_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clock,
   input  logic            clear_n,
   mem_interface_if.slave  bus
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                rd_q;
   logic                flag_q;
   logic [DATA_W-1:0]   mdata_q;
   logic [DATA_W-1:0]   ramDout;
   logic                accept;
   logic                lastCycle;
   logic                outOfRange;
   logic                ramWe;
   logic                doneW;
   logic                busyW;

   assign accept    = (state_q == IDLE) && (bus.read || bus.write);
   assign lastCycle = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_BOUNDS_CHECK_EN
   logic errQ_q;

   assign outOfRange = |bus.MARout[MAR_W-1:ADDR_W];
   assign bus.addr_err = errQ_q;

   // Error flag is cleared by a new acceptance and set together with mem_done.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         errQ_q <= 1'b0;
      end else if (accept) begin
         errQ_q <= 1'b0;
      end else if (lastCycle) begin
         errQ_q <= flag_q;
      end
   end
`else
   logic unusedUpper;

   assign unusedUpper = |bus.MARout[MAR_W-1:ADDR_W];
   assign outOfRange  = 1'b0;
`endif

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (bus.read || bus.write) state_d = ACCESS;
         ACCESS:   if (cnt_q == '0)           state_d = COMPLETE;
         COMPLETE:                            state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   // A write commits only on the final ACCESS edge, so an abort never reaches the RAM.
   always_comb begin
      busyW = (state_q != IDLE);
      doneW = (state_q == COMPLETE);
      ramWe = lastCycle && !rd_q && !flag_q;
   end

   // Read wins when both requests are high; address and data are frozen at acceptance.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= 1'b0;
         flag_q  <= 1'b0;
         mdata_q <= '0;
      end else begin
         if (accept) begin
            cnt_q  <= CNT_W'(WAIT_CYCLES);
            addr_q <= bus.MARout[ADDR_W-1:0];
            data_q <= bus.MDRout;
            rd_q   <= bus.read;
            flag_q <= outOfRange;
         end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (lastCycle && rd_q) begin
            mdata_q <= flag_q ? '0 : ramDout;
         end
      end
   end

   ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock (clock),
      .we    (ramWe),
      .addr  (addr_q),
      .din   (data_q),
      .dout  (ramDout)
   );

   assign bus.Mdatain  = mdata_q;
   assign bus.mem_done = doneW;
   assign bus.busy     = busyW;

endmodule

// File: tb/tb_mem_interface.sv
// Directed self-checking bench for mem_interface with WAIT_CYCLES=2; the
// bounds-check expectations follow MEM_BOUNDS_CHECK_EN when it is defined.
module tb_mem_interface;
   import mem_interface_pkg::*;

   localparam int WAIT = 2;

   logic clock   = 1'b0;
   logic clear_n = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   mem_interface_if bus();

   mem_interface #(
      .ADDR_W      (9),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
      bus.read   = rd;
      bus.write  = wr;
      bus.MARout = addr;
      bus.MDRout = data;
   endtask

   // One request: checks busy, exact mem_done latency, read data and return to idle.
   // The bus is scribbled after acceptance to show the latched values are used.
   task automatic runAccess(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] expMd);
      logic early;
      @(negedge clock);
      applyStimulus(rd, wr, addr, data);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0000_001F, 32'h0BAD_F00D);
      checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
      early = bus.mem_done;
      for (int i = 0; i < WAIT; i++) begin
         @(negedge clock);
         early = early | bus.mem_done;
      end
      checkOutput({tag, ".early_done"}, 32'(early), 32'd0);
      @(negedge clock);
      checkOutput({tag, ".done"}, 32'(bus.mem_done), 32'd1);
      checkOutput({tag, ".Mdatain"}, bus.Mdatain, expMd);
      @(negedge clock);
      checkOutput({tag, ".done_low"}, 32'(bus.mem_done), 32'd0);
      checkOutput({tag, ".idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int pulses;

      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      #1 clear_n = 1'b0;
      #2;
      checkOutput("reset.Mdatain", bus.Mdatain, 32'h0);
      checkOutput("reset.done", 32'(bus.mem_done), 32'd0);
      checkOutput("reset.busy", 32'(bus.busy), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
      checkOutput("reset.addr_err", 32'(bus.addr_err), 32'd0);
`endif
      @(negedge clock);
      clear_n = 1'b1;

      runAccess("wr05", 1'b0, 1'b1, 32'h05, 32'hDEAD_BEEF, 32'h0);
      runAccess("rd05", 1'b1, 1'b0, 32'h05, 32'h0, 32'hDEAD_BEEF);
      runAccess("wr20", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF);
      runAccess("both20", 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 32'h1234_5678);
      runAccess("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
      runAccess("wr07", 1'b0, 1'b1, 32'h07, 32'h0707_0707, 32'h1234_5678);
      runAccess("wr10", 1'b0, 1'b1, 32'h10, 32'h0000_1010, 32'h1234_5678);

      // Read held high through ACCESS and COMPLETE, dropped just before IDLE.
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.mem_done) pulses++;
         if (i == 4) bus.read = 1'b0;
      end
      checkOutput("held.pulses", 32'(pulses), 32'd1);
      checkOutput("held.Mdatain", bus.Mdatain, 32'h0000_1010);

      // Reset during ACCESS aborts a pending write.
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, 32'h07, 32'hCAFE_F00D);
      @(negedge clock);
      bus.write = 1'b0;
      @(negedge clock);
      checkOutput("abort.busy_before", 32'(bus.busy), 32'd1);
      #2 clear_n = 1'b0;
      #1;
      checkOutput("abort.Mdatain", bus.Mdatain, 32'h0);
      checkOutput("abort.busy", 32'(bus.busy), 32'd0);
      checkOutput("abort.done", 32'(bus.mem_done), 32'd0);
      @(negedge clock);
      clear_n = 1'b1;
      runAccess("rd07", 1'b1, 1'b0, 32'h07, 32'h0, 32'h0707_0707);

      runAccess("wr000", 1'b0, 1'b1, 32'h000, 32'h1111_1111, 32'h0707_0707);
      runAccess("wr200", 1'b0, 1'b1, 32'h200, 32'hAAAA_5555, 32'h0707_0707);
`ifdef MEM_BOUNDS_CHECK_EN
      checkOutput("wr200.addr_err", 32'(bus.addr_err), 32'd1);
      runAccess("rd000", 1'b1, 1'b0, 32'h000, 32'h0, 32'h1111_1111);
      checkOutput("rd000.addr_err", 32'(bus.addr_err), 32'd0);
      runAccess("rd200", 1'b1, 1'b0, 32'h200, 32'h0, 32'h0);
      checkOutput("rd200.addr_err", 32'(bus.addr_err), 32'd1);
`else
      runAccess("rd000", 1'b1, 1'b0, 32'h000, 32'h0, 32'hAAAA_5555);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
